// File: rtl/ped_signal_controller.sv
// Pedestrian WALK/DONT_WALK controller for a two-way crossing. Each crossing has
// its own debounced request latch and an IDLE/WALK/FLASH sequencer keyed to its green lamp.
module ped_signal_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int WALK_CYCLES     = 10,
   parameter int FLASH_CYCLES    = 8,
   parameter int FLASH_HALF      = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic ns_red,
   input  logic ns_yellow,
   input  logic ns_green,
   input  logic ew_red,
   input  logic ew_yellow,
   input  logic ew_green,
   input  logic ns_ped_btn,
   input  logic ew_ped_btn,
   output logic ns_walk,
   output logic ew_walk,
   output logic ns_dont_walk,
   output logic ew_dont_walk,
   output logic ns_req_pending,
   output logic ew_req_pending,
   output logic fault
);

   localparam int MAX_A = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
   localparam int MAX_B = (DEBOUNCE_CYCLES > FLASH_HALF) ? DEBOUNCE_CYCLES : FLASH_HALF;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_P + 1);

   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] WALK_LAST  = CW'(WALK_CYCLES - 1);
   localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(FLASH_HALF - 1);

   typedef enum logic [1:0] {IDLE, WALK, FLASH} ped_state_t;

   logic [1:0] btn_vec, green_vec, red_vec;
   logic [1:0] walk_vec, dont_walk_vec, pending_vec;
   logic       fault_reg, fault_cond, fault_set, ns_one_lamp, ew_one_lamp;

   assign btn_vec   = {ew_ped_btn, ns_ped_btn};
   assign green_vec = {ew_green, ns_green};
   assign red_vec   = {ew_red, ns_red};

   // Exactly one lamp lit: odd parity rules out 0 and 2, the AND term rules out 3.
   assign ns_one_lamp = (ns_red ^ ns_yellow ^ ns_green) & ~(ns_red & ns_yellow & ns_green);
   assign ew_one_lamp = (ew_red ^ ew_yellow ^ ew_green) & ~(ew_red & ew_yellow & ew_green);
   assign fault_cond  = (ns_green & ew_green) | ~ns_one_lamp | ~ew_one_lamp;
   assign fault_set   = fault_reg | fault_cond;

   always_ff @(posedge clk) begin
      if (reset)
         fault_reg <= 1'b0;
      else if (fault_cond)
         fault_reg <= 1'b1;
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic [1:0]    sync_reg;
         logic          level_reg, level_prev_reg, green_prev_reg;
         logic [CW-1:0] deb_cnt_reg, int_cnt_reg, half_cnt_reg;
         logic          walk_reg, dont_walk_reg, pending_reg;
         ped_state_t    state_reg;
         logic          press_rise, green_rise;

         assign press_rise = level_reg & ~level_prev_reg;
         assign green_rise = green_vec[gi] & ~green_prev_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               sync_reg       <= 2'b00;
               level_reg      <= 1'b0;
               level_prev_reg <= 1'b0;
               deb_cnt_reg    <= '0;
            end else begin
               sync_reg       <= {sync_reg[0], btn_vec[gi]};
               level_prev_reg <= level_reg;
               if (sync_reg[1] != level_reg) begin
                  if (deb_cnt_reg == DEB_LAST) begin
                     level_reg   <= sync_reg[1];
                     deb_cnt_reg <= '0;
                  end else begin
                     deb_cnt_reg <= deb_cnt_reg + 1'b1;
                  end
               end else begin
                  deb_cnt_reg <= '0;
               end
            end
         end

         // Lamp registers are loaded alongside the state so they always decode the state register.
         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg      <= IDLE;
               int_cnt_reg    <= '0;
               half_cnt_reg   <= '0;
               walk_reg       <= 1'b0;
               dont_walk_reg  <= 1'b1;
               pending_reg    <= 1'b0;
               green_prev_reg <= 1'b1;
            end else begin
               green_prev_reg <= green_vec[gi];
               if (fault_set) begin
                  state_reg     <= IDLE;
                  int_cnt_reg   <= '0;
                  half_cnt_reg  <= '0;
                  walk_reg      <= 1'b0;
                  dont_walk_reg <= 1'b1;
                  pending_reg   <= 1'b0;
               end else begin
                  case (state_reg)
                     IDLE: begin
                        if (green_rise && pending_reg) begin
                           state_reg     <= WALK;
                           int_cnt_reg   <= '0;
                           walk_reg      <= 1'b1;
                           dont_walk_reg <= 1'b0;
                           pending_reg   <= 1'b0;
                        end else if (press_rise) begin
                           pending_reg <= 1'b1;
                        end
                     end
                     WALK: begin
                        if (!green_vec[gi] || int_cnt_reg == WALK_LAST) begin
                           state_reg     <= FLASH;
                           int_cnt_reg   <= '0;
                           half_cnt_reg  <= '0;
                           walk_reg      <= 1'b0;
                           dont_walk_reg <= 1'b1;
                        end else begin
                           int_cnt_reg <= int_cnt_reg + 1'b1;
                        end
                     end
                     FLASH: begin
                        if (red_vec[gi] || int_cnt_reg == FLASH_LAST) begin
                           state_reg     <= IDLE;
                           int_cnt_reg   <= '0;
                           half_cnt_reg  <= '0;
                           dont_walk_reg <= 1'b1;
                        end else begin
                           int_cnt_reg <= int_cnt_reg + 1'b1;
                           if (half_cnt_reg == HALF_LAST) begin
                              half_cnt_reg  <= '0;
                              dont_walk_reg <= ~dont_walk_reg;
                           end else begin
                              half_cnt_reg <= half_cnt_reg + 1'b1;
                           end
                        end
                     end
                     default: begin
                        state_reg     <= IDLE;
                        walk_reg      <= 1'b0;
                        dont_walk_reg <= 1'b1;
                     end
                  endcase
               end
            end
         end

         assign walk_vec[gi]      = walk_reg;
         assign dont_walk_vec[gi] = dont_walk_reg;
         assign pending_vec[gi]   = pending_reg;
      end
   endgenerate

   assign ns_walk        = walk_vec[0];
   assign ew_walk        = walk_vec[1];
   assign ns_dont_walk   = dont_walk_vec[0];
   assign ew_dont_walk   = dont_walk_vec[1];
   assign ns_req_pending = pending_vec[0];
   assign ew_req_pending = pending_vec[1];
   assign fault          = fault_reg;

endmodule

// File: tb/tb_ped_signal_controller.sv
// Scoreboard bench: stimulus queues cycle-tagged expected lamp vectors,
// a negedge monitor compares them against the sampled outputs.
module tb_ped_signal_controller;

   logic clk = 1'b0;
   logic reset;
   logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
   logic ns_ped_btn, ew_ped_btn;
   logic ns_walk, ew_walk, ns_dont_walk, ew_dont_walk;
   logic ns_req_pending, ew_req_pending, fault;

   ped_signal_controller dut (
      .clk(clk), .reset(reset),
      .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
      .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
      .ns_ped_btn(ns_ped_btn), .ew_ped_btn(ew_ped_btn),
      .ns_walk(ns_walk), .ew_walk(ew_walk),
      .ns_dont_walk(ns_dont_walk), .ew_dont_walk(ew_dont_walk),
      .ns_req_pending(ns_req_pending), .ew_req_pending(ew_req_pending),
      .fault(fault)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] NSW = 7'h01, NSDW = 7'h02, EWW = 7'h04, EWDW = 7'h08;
   localparam logic [6:0] NSP = 7'h10, EWP = 7'h20, FLT = 7'h40, ALL = 7'h7F;
   localparam logic [6:0] RST_VAL = 7'h0A;
   localparam int RED = 0, YEL = 1, GRN = 2;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   int         q_cyc[$];
   logic [6:0] q_mask[$];
   logic [6:0] q_val[$];
   string      q_name[$];

   logic [6:0] out_vec;
   assign out_vec = {fault, ew_req_pending, ns_req_pending, ew_dont_walk, ew_walk,
                     ns_dont_walk, ns_walk};

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every cycle, retire all expectations tagged for this cycle.
   always @(negedge clk) begin
      for (int i = q_cyc.size() - 1; i >= 0; i--) begin
         if (q_cyc[i] <= cyc) begin
            vectors++;
            if (q_cyc[i] < cyc) begin
               miscompares++;
               $display("FAIL %s cyc %0d: expectation for cyc %0d was never checked",
                        q_name[i], cyc, q_cyc[i]);
            end else if ((out_vec & q_mask[i]) !== (q_val[i] & q_mask[i])) begin
               miscompares++;
               $display("FAIL %s cyc %0d: got %b required %b (mask %b)",
                        q_name[i], cyc, out_vec & q_mask[i], q_val[i] & q_mask[i], q_mask[i]);
            end else begin
               $display("ok   %s cyc %0d: %b", q_name[i], cyc, out_vec & q_mask[i]);
            end
            q_cyc.delete(i);
            q_mask.delete(i);
            q_val.delete(i);
            q_name.delete(i);
         end
      end
   end

   task automatic expect_at(input int c, input logic [6:0] m, input logic [6:0] v,
                            input string nm);
      q_cyc.push_back(c);
      q_mask.push_back(m);
      q_val.push_back(v);
      q_name.push_back(nm);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ns(input int c);
      ns_red    = (c == RED);
      ns_yellow = (c == YEL);
      ns_green  = (c == GRN);
   endtask

   task automatic set_ew(input int c);
      ew_red    = (c == RED);
      ew_yellow = (c == YEL);
      ew_green  = (c == GRN);
   endtask

   initial begin
      int k, m, a, f, r;
      logic [7:0] flash8;
      logic [4:0] flash5;
      flash8 = 8'b00110011;  // bit i = dont_walk on FLASH cycle i
      flash5 = 5'b10011;

      reset = 1'b1; ns_ped_btn = 1'b0; ew_ped_btn = 1'b0;
      set_ns(GRN); set_ew(RED);
      for (int i = 1; i <= 3; i++) expect_at(i, ALL, RST_VAL, "reset_hold");
      tick(3);
      reset = 1'b0;
      // Green already lit at release must not start anything.
      expect_at(cyc + 1, ALL, RST_VAL, "post_reset");
      expect_at(cyc + 2, ALL, RST_VAL, "post_reset");

      // Two-cycle blip on NS button during NS red is rejected.
      set_ns(RED); set_ew(GRN);
      tick(2);
      k = cyc;
      for (int i = 1; i <= 10; i++) expect_at(k + i, NSP, 7'h00, "short_press");
      ns_ped_btn = 1'b1;
      tick(2);
      ns_ped_btn = 1'b0;
      tick(10);

      // Held press latches on the 7th edge.
      k = cyc;
      expect_at(k + 6, NSP, 7'h00, "deb_before");
      expect_at(k + 7, NSP | NSW, NSP, "deb_latch");
      ns_ped_btn = 1'b1;
      tick(9);
      ns_ped_btn = 1'b0;
      tick(12);

      // Full WALK then FLASH then IDLE.
      m = cyc;
      expect_at(m, NSP | NSW, NSP, "walk_wait");
      for (int i = 1; i <= 10; i++) expect_at(m + i, NSW | NSDW | NSP, NSW, "walk_full");
      for (int i = 0; i < 8; i++)
         expect_at(m + 11 + i, NSW | NSDW, flash8[i] ? NSDW : 7'h00, "flash_full");
      expect_at(m + 19, NSW | NSDW, NSDW, "idle_after_flash");
      expect_at(m + 20, NSW | NSDW, NSDW, "idle_after_flash");
      set_ns(GRN); set_ew(RED);
      tick(21);

      // Green drops mid-WALK, red cuts FLASH short.
      set_ns(RED); set_ew(GRN);
      tick(2);
      k = cyc;
      expect_at(k + 7, NSP, NSP, "second_req");
      ns_ped_btn = 1'b1;
      tick(8);
      ns_ped_btn = 1'b0;
      tick(12);
      m = cyc;
      for (int i = 1; i <= 5; i++) expect_at(m + i, NSW | NSDW, NSW, "walk_cut");
      for (int i = 0; i < 5; i++)
         expect_at(m + 6 + i, NSW | NSDW, flash5[i] ? NSDW : 7'h00, "flash_cut");
      expect_at(m + 11, NSW | NSDW, NSDW, "idle_on_red");
      expect_at(m + 12, NSW | NSDW, NSDW, "idle_on_red");
      set_ns(GRN); set_ew(RED);
      tick(5);
      set_ns(YEL);
      tick(5);
      set_ns(RED);
      tick(3);

      // EW request during EW green waits for the next green rise.
      a = cyc;
      for (int i = 1; i <= 22; i++) expect_at(a + i, EWW, 7'h00, "ew_hold_off");
      expect_at(a + 8, EWP, 7'h00, "ew_pend_before");
      expect_at(a + 9, EWP, EWP, "ew_pend_set");
      set_ew(GRN);
      tick(2);
      ew_ped_btn = 1'b1;
      tick(8);
      ew_ped_btn = 1'b0;
      tick(10);
      set_ew(RED);
      tick(3);
      expect_at(a + 23, EWW | EWP, EWP, "ew_before_rise");
      expect_at(a + 24, EWW | EWP | EWDW, EWW, "ew_walk_start");
      set_ew(GRN);
      tick(4);

      // Both greens for one cycle: sticky fault, everything forced idle.
      f = cyc;
      expect_at(f, FLT | EWW, EWW, "pre_fault");
      expect_at(f + 1, FLT | EWW | NSW | EWDW, FLT | EWDW, "fault_set");
      set_ns(GRN);
      tick(1);
      set_ns(RED);
      expect_at(f + 5, FLT | EWW | NSW, FLT, "fault_sticky");
      expect_at(f + 12, FLT | NSP | NSW, FLT, "fault_ignores_req");
      ns_ped_btn = 1'b1;
      tick(10);
      ns_ped_btn = 1'b0;
      tick(3);
      r = cyc;
      expect_at(r + 1, ALL, RST_VAL, "fault_cleared");
      expect_at(r + 3, ALL, RST_VAL, "after_reset");
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(4);

      for (int i = 0; i < 20 && q_cyc.size() > 0; i++) tick(1);
      if (q_cyc.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", q_cyc.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
